// File: rtl/fila_drain_tx.sv
// fila_drain_tx: drains the byte queue one entry at a time and retransmits
// each byte as an MSB-first serial frame on clk_1MHz.
// Optional feature macro: DRAIN_PARITY_EN (adds an even-parity bit per frame).
module fila_drain_tx #(
    parameter int DEQ_HOLD   = 100,
    parameter int BIT_DIV    = 10,
    parameter int GAP_CYCLES = 200
) (
    input  logic       clk_1MHz,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] fila_len_in,
    input  logic [7:0] fila_data_in,
    output logic       dequeue_out,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       busy,
    output logic [7:0] sent_count
);

`ifdef DRAIN_PARITY_EN
    typedef enum logic [2:0] {IDLE, DEQ, SHIFT, PARITY, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, DEQ, SHIFT, GAP} state_t;
`endif

    state_t      r_state, w_state_nx;
    logic [15:0] r_cnt,   w_cnt_nx;
    logic [2:0]  r_bit,   w_bit_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic [7:0]  r_sent,  w_sent_nx;
    logic        w_ser_nx;
    logic        r_deq, r_ser, r_valid, r_busy;
`ifdef DRAIN_PARITY_EN
    logic        r_par, w_par_nx;
`endif

    // Next-state, counters and next output values; outputs are registered below.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_sent_nx  = r_sent;
        w_ser_nx   = 1'b0;
`ifdef DRAIN_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            IDLE: begin
                if (tx_en && (fila_len_in != 8'd0)) begin
                    w_state_nx = DEQ;
                    w_cnt_nx   = 16'd0;
                    w_shift_nx = fila_data_in;
`ifdef DRAIN_PARITY_EN
                    w_par_nx   = ^fila_data_in;
`endif
                end
            end
            DEQ: begin
                if (r_cnt == 16'(DEQ_HOLD - 1)) begin
                    w_state_nx = SHIFT;
                    w_cnt_nx   = 16'd0;
                    w_bit_nx   = 3'd0;
                    w_ser_nx   = r_shift[7];
                end else begin
                    w_cnt_nx   = r_cnt + 16'd1;
                end
            end
            SHIFT: begin
                w_ser_nx = r_shift[7];
                if (r_cnt == 16'(BIT_DIV - 1)) begin
                    w_cnt_nx = 16'd0;
                    if (r_bit == 3'd7) begin
`ifdef DRAIN_PARITY_EN
                        w_state_nx = PARITY;
                        w_ser_nx   = r_par;
`else
                        w_state_nx = GAP;
                        w_ser_nx   = 1'b0;
`endif
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {r_shift[6:0], 1'b0};
                        w_ser_nx   = r_shift[6];
                    end
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end
`ifdef DRAIN_PARITY_EN
            PARITY: begin
                w_ser_nx = r_par;
                if (r_cnt == 16'(BIT_DIV - 1)) begin
                    w_state_nx = GAP;
                    w_cnt_nx   = 16'd0;
                    w_ser_nx   = 1'b0;
                end else begin
                    w_cnt_nx   = r_cnt + 16'd1;
                end
            end
`endif
            GAP: begin
                if (r_cnt == 16'(GAP_CYCLES - 1)) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = 16'd0;
                    w_sent_nx  = r_sent + 8'd1;
                end else begin
                    w_cnt_nx   = r_cnt + 16'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset drops everything at once.
    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_sent  <= 8'd0;
            r_deq   <= 1'b0;
            r_ser   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef DRAIN_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_sent  <= w_sent_nx;
            r_deq   <= (w_state_nx == DEQ);
            r_ser   <= w_ser_nx;
`ifdef DRAIN_PARITY_EN
            r_valid <= (w_state_nx == SHIFT) || (w_state_nx == PARITY);
            r_par   <= w_par_nx;
`else
            r_valid <= (w_state_nx == SHIFT);
`endif
            r_busy  <= (w_state_nx != IDLE);
        end
    end

    assign dequeue_out = r_deq;
    assign ser_out     = r_ser;
    assign ser_valid   = r_valid;
    assign busy        = r_busy;
    assign sent_count  = r_sent;

endmodule
